pll_reset_sequencer: RTL and testbench

Reset sequencer directly downstream of the 16→50 MHz PLL. It consumes the PLL `locked` flag and, in the 50 MHz PLL output domain, releases the system resets in two staggered stages only after lock has been continuously stable for a qualification window. On loss of lock after release, it re-asserts both resets at once, counts the event, and waits a hold-off period before it requalifies.

---
 rtl/pll_reset_sequencer.sv | 169 ++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Releases the system resets in two staggered stages once the PLL lock flag
//   has been continuously stable for a qualification window. On loss of lock
//   after release, both resets re-assert together, the loss is counted, and a
//   hold-off period passes before requalification begins.
//
// Ports
//   clock            in   50 MHz PLL output clock (only clock)
//   reset_n          in   asynchronous active-low reset
//   locked           in   PLL lock flag, asynchronous to clock
//   reset_core_n     out  registered active-low core reset (released first)
//   reset_io_n       out  registered active-low I/O reset (released second)
//   ready            out  high only in RUN
//   lock_loss_count  out  lock losses after release, saturating at 255
module pll_reset_sequencer #(
  parameter int unsigned LOCK_CYCLES    = 50000,
  parameter int unsigned STAGGER_CYCLES = 16,
  parameter int unsigned HOLDOFF_CYCLES = 1000,
  parameter int unsigned COUNT_WIDTH    = 17
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       locked,
  output logic       reset_core_n,
  output logic       reset_io_n,
  output logic       ready,
  output logic [7:0] lock_loss_count
);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    QUALIFY,
    STAGGER,
    RUN,
    HOLDOFF
  } state_t;

  // The cycle that moves WAIT_LOCK -> QUALIFY already counts as the first
  // qualified lock cycle, so QUALIFY finishes when the running count
  // reaches LOCK_CYCLES-1 (core release lands LOCK_CYCLES edges after
  // lock_s is first seen high).
  localparam logic [COUNT_WIDTH-1:0] LOCK_LAST    = COUNT_WIDTH'(LOCK_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] STAGGER_LAST = COUNT_WIDTH'(STAGGER_CYCLES);
  localparam logic [COUNT_WIDTH-1:0] HOLDOFF_LAST = COUNT_WIDTH'(HOLDOFF_CYCLES);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE      = COUNT_WIDTH'(1);

  logic                   sync0;
  logic                   sync1;
  logic                   lock_s;

  state_t                 state;
  state_t                 state_next;
  logic [COUNT_WIDTH-1:0] cnt;
  logic [COUNT_WIDTH-1:0] cnt_next;
  logic                   loss;

  logic                   core_d;
  logic                   io_d;
  logic                   ready_d;

  assign lock_s = sync1;

  // State register, synchronizer, counters and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync0           <= 1'b0;
      sync1           <= 1'b0;
      state           <= WAIT_LOCK;
      cnt             <= '0;
      reset_core_n    <= 1'b0;
      reset_io_n      <= 1'b0;
      ready           <= 1'b0;
      lock_loss_count <= '0;
    end else begin
      sync0        <= locked;
      sync1        <= sync0;
      state        <= state_next;
      cnt          <= cnt_next;
      reset_core_n <= core_d;
      reset_io_n   <= io_d;
      ready        <= ready_d;
      if (loss && (lock_loss_count != 8'hFF)) begin
        lock_loss_count <= lock_loss_count + 8'd1;
      end
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    loss       = 1'b0;
    case (state)
      WAIT_LOCK: begin
        cnt_next = '0;
        if (lock_s) begin
          cnt_next   = CNT_ONE;
          state_next = (LOCK_CYCLES == 1) ? STAGGER : QUALIFY;
        end
      end
      QUALIFY: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt == LOCK_LAST) begin
          state_next = STAGGER;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      STAGGER: begin
        // Lock loss takes priority over stagger completion
        if (!lock_s) begin
          state_next = HOLDOFF;
          cnt_next   = CNT_ONE;
          loss       = 1'b1;
        end else if (cnt == STAGGER_LAST) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      RUN: begin
        cnt_next = '0;
        if (!lock_s) begin
          state_next = HOLDOFF;
          cnt_next   = CNT_ONE;
          loss       = 1'b1;
        end
      end
      HOLDOFF: begin
        if (cnt == HOLDOFF_LAST) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = WAIT_LOCK;
        cnt_next   = '0;
      end
    endcase
  end

  // Output decode from the next state; io release is a subset of core
  // release, so an io-only state cannot be produced.
  always_comb begin
    core_d  = 1'b0;
    io_d    = 1'b0;
    ready_d = 1'b0;
    case (state_next)
      STAGGER: core_d = 1'b1;
      RUN: begin
        core_d  = 1'b1;
        io_d    = 1'b1;
        ready_d = 1'b1;
      end
      default: begin
        core_d  = 1'b0;
        io_d    = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
//   Directed bench for pll_reset_sequencer with LOCK=8, STAGGER=4, HOLDOFF=6.
//   Output vector is {reset_core_n, reset_io_n, ready, lock_loss_count}.
//   Stimulus pushes the expected (edge, vector) of every output change into a
//   queue; the monitor pops an entry whenever the sampled vector changes.
module tb_pll_reset_sequencer;

  localparam int unsigned LOCK_CYCLES    = 8;
  localparam int unsigned STAGGER_CYCLES = 4;
  localparam int unsigned HOLDOFF_CYCLES = 6;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       locked;
  logic       reset_core_n;
  logic       reset_io_n;
  logic       ready;
  logic [7:0] lock_loss_count;
  logic [10:0] act;

  pll_reset_sequencer #(
    .LOCK_CYCLES    (LOCK_CYCLES),
    .STAGGER_CYCLES (STAGGER_CYCLES),
    .HOLDOFF_CYCLES (HOLDOFF_CYCLES),
    .COUNT_WIDTH    (17)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .locked          (locked),
    .reset_core_n    (reset_core_n),
    .reset_io_n      (reset_io_n),
    .ready           (ready),
    .lock_loss_count (lock_loss_count)
  );

  always #5 clock = ~clock;

  assign act = {reset_core_n, reset_io_n, ready, lock_loss_count};

  typedef struct {
    int          edge_no;
    logic [10:0] vec;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   edge_n  = 0;
  int   exp_cnt = 0;

  always @(posedge clock) edge_n <= edge_n + 1;

  function automatic logic [10:0] mk(input logic c, input logic i, input logic r, input int n);
    logic [7:0] n8;
    n8 = n[7:0];
    return {c, i, r, n8};
  endfunction

  task automatic chk(input string name, input logic [10:0] a, input logic [10:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, a, e);
    end
  endtask

  task automatic push(input int e, input logic c, input logic i, input logic r, input string name);
    exp_t x;
    x.edge_no = e;
    x.vec     = mk(c, i, r, exp_cnt);
    x.name    = name;
    exp_q.push_back(x);
  endtask

  // Returns at the falling edge that follows rising edge e.
  task automatic to_edge(input int e);
    while (edge_n < e) @(negedge clock);
  endtask

  // locked low for exactly one cycle, first sampled low at edge s.
  task automatic drop_lock(input int s);
    to_edge(s - 1);
    locked = 1'b0;
    @(negedge clock);
    locked = 1'b1;
  endtask

  // One lock loss sampled at edge s: all outputs fall after s+2, then
  // holdoff (6) and requalification (8) put the core release at s+16.
  task automatic loss_cycle(input int s, input string name, output int core_edge);
    if (exp_cnt < 255) exp_cnt++;
    push(s + 2, 1'b0, 1'b0, 1'b0, name);
    core_edge = s + 2 + int'(HOLDOFF_CYCLES) + int'(LOCK_CYCLES);
    push(core_edge, 1'b1, 1'b0, 1'b0, "requal_core");
    drop_lock(s);
  endtask

  // Monitor: decoupled from stimulus, checks every output change
  initial begin : monitor
    logic [10:0] prev;
    exp_t        e;
    prev = '0;
    forever begin
      @(negedge clock);
      checks++;
      if (reset_io_n === 1'b1 && reset_core_n !== 1'b1) begin
        errors++;
        $display("FAIL io_only_release: actual core %b io %b required core 1", reset_core_n, reset_io_n);
      end
      if (act !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: actual edge %0d vec %h required no change", edge_n, act);
        end else begin
          e = exp_q.pop_front();
          if (e.vec !== act || e.edge_no != edge_n) begin
            errors++;
            $display("FAIL %s: actual edge %0d vec %h required edge %0d vec %h",
                     e.name, edge_n, act, e.edge_no, e.vec);
          end
        end
        prev = act;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int s;
    int c;

    // Reset values with locked already high
    reset_n = 1'b0;
    locked  = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_hold", act, mk(1'b0, 1'b0, 1'b0, 0));

    // Clean release: edge 1 samples locked, core after 10, io/ready after 14
    base    = edge_n;
    reset_n = 1'b1;
    push(base + 10, 1'b1, 1'b0, 1'b0, "clean_core");
    push(base + 14, 1'b1, 1'b1, 1'b1, "clean_io");
    to_edge(base + 17);
    chk("clean_run", act, mk(1'b1, 1'b1, 1'b1, 0));

    // Loss in RUN, lock restored at once, full 8+4 requalification
    s = edge_n + 1;
    loss_cycle(s, "run_loss", c);
    push(c + 4, 1'b1, 1'b1, 1'b1, "run_requal_io");
    to_edge(c + 6);

    // Loss in RUN again, then loss 2 cycles into STAGGER (io never rises)
    s = edge_n + 1;
    loss_cycle(s, "run_loss2", c);
    loss_cycle(c + 2, "stagger_loss", c);

    // Saturation: 257 more STAGGER losses, 260 in total
    for (int n = 0; n < 257; n++) begin
      loss_cycle(c + 1, "sat_loss", c);
    end
    to_edge(c + 1);
    chk("saturated_stagger", act, mk(1'b1, 1'b0, 1'b0, 255));

    // Mid-sequence reset during STAGGER: immediate, clears the count
    exp_cnt = 0;
    push(edge_n + 1, 1'b0, 1'b0, 1'b0, "mid_reset");
    #2 reset_n = 1'b0;
    #1 chk("mid_reset_async", act, mk(1'b0, 1'b0, 1'b0, 0));
    @(negedge clock);
    @(negedge clock);
    chk("mid_reset_hold", act, mk(1'b0, 1'b0, 1'b0, 0));
    base    = edge_n;
    reset_n = 1'b1;
    push(base + 10, 1'b1, 1'b0, 1'b0, "mid_core");
    push(base + 14, 1'b1, 1'b1, 1'b1, "mid_io");
    to_edge(base + 17);

    // Qualify abort: high for edges 1..5, low at 6, high again from 7;
    // core rises 9 edges after edge 7 (edge 16), io at 20, no count
    push(edge_n + 1, 1'b0, 1'b0, 1'b0, "abort_reset");
    #2 reset_n = 1'b0;
    locked = 1'b0;
    @(negedge clock);
    @(negedge clock);
    base    = edge_n;
    reset_n = 1'b1;
    locked  = 1'b1;
    to_edge(base + 5);
    locked = 1'b0;
    @(negedge clock);
    locked = 1'b1;
    push(base + 16, 1'b1, 1'b0, 1'b0, "abort_core");
    push(base + 20, 1'b1, 1'b1, 1'b1, "abort_io");
    to_edge(base + 23);
    chk("abort_final", act, mk(1'b1, 1'b1, 1'b1, 0));

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: actual %0d outstanding required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
